// File: rtl/lookup_scan_ctrl_if.sv
// Interface bundling the control, mux and status signals of lookup_scan_ctrl.
interface lookup_scan_ctrl_if #(
   parameter int NCH     = 32,
   parameter int IDX_W   = 5,
   parameter int DWELL_W = 16
);
   logic               start;
   logic               abort;
   logic               loop;
   logic [NCH-1:0]     enable_mask;
   logic [DWELL_W-1:0] dwell;
   logic               pulse_in;
   logic [NCH-1:0]     select;
   logic [IDX_W-1:0]   chan_idx;
   logic               busy;
   logic               done;
   logic [NCH-1:0]     hit_mask;

   // Controller side: drives commands and the mux output, observes status.
   modport master (
      output start, abort, loop, enable_mask, dwell, pulse_in,
      input  select, chan_idx, busy, done, hit_mask
   );

   // Sequencer side.
   modport slave (
      input  start, abort, loop, enable_mask, dwell, pulse_in,
      output select, chan_idx, busy, done, hit_mask
   );
endinterface

// File: rtl/lookup_scan_ctrl.sv
// Scan sequencer for the pulse look-up mux: walks the latched channel mask,
// dwells on each channel and records which channels showed a pulse.
module lookup_scan_ctrl #(
   parameter int NCH     = 32,
   parameter int IDX_W   = 5,
   parameter int DWELL_W = 16
) (
   input logic              clk,
   input logic              rst,
   lookup_scan_ctrl_if.slave bus
);

   typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

   state_t             r_state,  w_state_next;
   logic [NCH-1:0]     r_mask,   w_mask_next;
   logic               r_loop,   w_loop_next;
   logic [DWELL_W-1:0] r_dwell,  w_dwell_next;
   logic [DWELL_W-1:0] r_cnt,    w_cnt_next;
   logic [IDX_W-1:0]   r_idx,    w_idx_next;
   logic [NCH-1:0]     r_acc,    w_acc_next;
   logic [NCH-1:0]     r_hit,    w_hit_next;
   logic               r_done,   w_done_next;

   logic [NCH-1:0]     w_above;
   logic               w_has_next;
   logic [IDX_W-1:0]   w_next_idx;
   logic [IDX_W-1:0]   w_first_idx;
   logic [IDX_W-1:0]   w_start_idx;
   logic [DWELL_W-1:0] w_dwell_eff;
   logic [NCH-1:0]     w_acc_cur;

   // Index of the lowest set bit (0 when none set; callers guard on that).
   function automatic logic [IDX_W-1:0] f_lowest(input logic [NCH-1:0] m);
      logic [IDX_W-1:0] r;
      r = '0;
      for (int i = NCH - 1; i >= 0; i--) begin
         if (m[i]) r = IDX_W'(i);
      end
      return r;
   endfunction

   // Enabled channels strictly above the current one.
   genvar gi;
   generate
      for (gi = 0; gi < NCH; gi++) begin : g_above
         assign w_above[gi] = r_mask[gi] && (IDX_W'(gi) > r_idx);
      end
   endgenerate

   assign w_has_next  = |w_above;
   assign w_next_idx  = f_lowest(w_above);
   assign w_first_idx = f_lowest(r_mask);
   assign w_start_idx = f_lowest(bus.enable_mask);
   assign w_dwell_eff = (bus.dwell == '0) ? DWELL_W'(1) : bus.dwell;
   // Accumulator including this cycle's sample (pulse_in follows select combinationally).
   assign w_acc_cur   = r_acc | (NCH'(bus.pulse_in) << r_idx);

   assign bus.select   = (r_state == S_SCAN) ? (NCH'(1) << r_idx) : '0;
   assign bus.busy     = (r_state == S_SCAN);
   assign bus.done     = r_done;
   assign bus.chan_idx = r_idx;
   assign bus.hit_mask = r_hit;

   // Next-state and datapath updates; abort overrides everything but reset.
   always_comb begin
      w_state_next = r_state;
      w_mask_next  = r_mask;
      w_loop_next  = r_loop;
      w_dwell_next = r_dwell;
      w_cnt_next   = r_cnt;
      w_idx_next   = r_idx;
      w_acc_next   = r_acc;
      w_hit_next   = r_hit;
      w_done_next  = 1'b0;

      if (bus.abort) begin
         w_state_next = S_IDLE;
         w_acc_next   = '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.start) begin
                  if (bus.enable_mask != '0) begin
                     w_state_next = S_SCAN;
                     w_mask_next  = bus.enable_mask;
                     w_loop_next  = bus.loop;
                     w_dwell_next = w_dwell_eff;
                     w_cnt_next   = w_dwell_eff - DWELL_W'(1);
                     w_idx_next   = w_start_idx;
                     w_acc_next   = '0;
                  end else begin
                     w_state_next = S_DONE;
                     w_hit_next   = '0;
                     w_done_next  = 1'b1;
                  end
               end
            end
            S_SCAN: begin
               w_acc_next = w_acc_cur;
               if (r_cnt != '0) begin
                  w_cnt_next = r_cnt - DWELL_W'(1);
               end else if (w_has_next) begin
                  w_idx_next = w_next_idx;
                  w_cnt_next = r_dwell - DWELL_W'(1);
               end else begin
                  w_hit_next  = w_acc_cur;
                  w_done_next = 1'b1;
                  if (r_loop) begin
                     w_idx_next = w_first_idx;
                     w_cnt_next = r_dwell - DWELL_W'(1);
                     w_acc_next = '0;
                  end else begin
                     w_state_next = S_DONE;
                  end
               end
            end
            S_DONE: begin
               w_state_next = S_IDLE;
            end
            default: begin
               w_state_next = S_IDLE;
            end
         endcase
      end
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_mask  <= '0;
         r_loop  <= 1'b0;
         r_dwell <= DWELL_W'(1);
         r_cnt   <= '0;
         r_idx   <= '0;
         r_acc   <= '0;
         r_hit   <= '0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_mask  <= w_mask_next;
         r_loop  <= w_loop_next;
         r_dwell <= w_dwell_next;
         r_cnt   <= w_cnt_next;
         r_idx   <= w_idx_next;
         r_acc   <= w_acc_next;
         r_hit   <= w_hit_next;
         r_done  <= w_done_next;
      end
   end

endmodule

// File: tb/tb_lookup_scan_ctrl.sv
// Directed, scoreboard-driven bench for lookup_scan_ctrl.
module tb_lookup_scan_ctrl;

   logic        clk;
   logic        rst;
   logic [31:0] pulse_bus;
   int          n_cmp;
   int          n_fail;

   typedef struct packed {
      logic [31:0] sel;
      logic [4:0]  idx;
      logic        busy;
      logic        done;
   } exp_t;

   exp_t q[$];

   lookup_scan_ctrl_if #(.NCH(32), .IDX_W(5), .DWELL_W(16)) bus ();

   lookup_scan_ctrl #(.NCH(32), .IDX_W(5), .DWELL_W(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   // Behavioural model of the pulse look-up mux.
   assign bus.pulse_in = |(bus.select & pulse_bus);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [31:0] sel, input logic [4:0] idx,
                       input logic busy, input logic done);
      exp_t e;
      e.sel = sel; e.idx = idx; e.busy = busy; e.done = done;
      q.push_back(e);
   endtask

   // n scanning cycles on channel idx; done flagged on the first if requested.
   task automatic push_ch(input int idx, input int n, input logic done_first);
      logic [31:0] one;
      one = 32'd1;
      for (int k = 0; k < n; k++)
         push(one << idx, 5'(idx), 1'b1, (k == 0) ? done_first : 1'b0);
   endtask

   // Advance n cycles, comparing each against the scoreboard head.
   task automatic drain(input int n, input string tag);
      exp_t e;
      for (int k = 0; k < n; k++) begin
         @(posedge clk); #1;
         bus.start = 1'b0;
         if (q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s scoreboard_empty observed=none expected=entry", tag);
         end else begin
            e = q.pop_front();
            chk({tag, ".select"},   bus.select,         e.sel);
            chk({tag, ".chan_idx"}, 32'(bus.chan_idx),  32'(e.idx));
            chk({tag, ".busy"},     32'(bus.busy),      32'(e.busy));
            chk({tag, ".done"},     32'(bus.done),      32'(e.done));
            $display("[%0t] %s sel=%h idx=%0d busy=%0b done=%0b hit=%h",
                     $time, tag, bus.select, bus.chan_idx, bus.busy, bus.done, bus.hit_mask);
         end
      end
   endtask

   task automatic setup_basic();
      pulse_bus       = 32'h0000_000A;
      bus.enable_mask = 32'h0000_0016;
      bus.dwell       = 16'd3;
      bus.loop        = 1'b0;
      bus.start       = 1'b1;
   endtask

   initial begin
      int n_done;
      n_cmp = 0; n_fail = 0;
      rst = 1'b1;
      pulse_bus = '0;
      bus.start = 1'b0; bus.abort = 1'b0; bus.loop = 1'b0;
      bus.enable_mask = '0; bus.dwell = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset.select", bus.select, 32'h0);
      chk("reset.busy", 32'(bus.busy), 32'h0);
      chk("reset.done", 32'(bus.done), 32'h0);
      chk("reset.chan_idx", 32'(bus.chan_idx), 32'h0);
      chk("reset.hit_mask", bus.hit_mask, 32'h0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Basic single pass over channels 1,2,4.
      setup_basic();
      push_ch(1, 3, 1'b0); push_ch(2, 3, 1'b0); push_ch(4, 3, 1'b0);
      push(32'h0, 5'd4, 1'b0, 1'b1);
      push(32'h0, 5'd4, 1'b0, 1'b0);
      drain(11, "basic");
      chk("basic.hit_mask", bus.hit_mask, 32'h0000_0002);

      // Empty mask: a lone done pulse, select never driven.
      bus.enable_mask = '0;
      bus.start = 1'b1;
      n_done = 0;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         bus.start = 1'b0;
         if (bus.done) n_done++;
         chk("empty.select", bus.select, 32'h0);
      end
      chk("empty.done_count", 32'(n_done), 32'd1);
      chk("empty.hit_mask", bus.hit_mask, 32'h0);

      // Zero dwell behaves as one cycle.
      pulse_bus = 32'h0000_0008;
      bus.enable_mask = 32'h0000_0008;
      bus.dwell = 16'd0;
      bus.start = 1'b1;
      push(32'h8, 5'd3, 1'b1, 1'b0);
      push(32'h0, 5'd3, 1'b0, 1'b1);
      push(32'h0, 5'd3, 1'b0, 1'b0);
      drain(3, "dwell0");
      chk("dwell0.hit_mask", bus.hit_mask, 32'h0000_0008);

      // Loop mode wrapping from bit 31 back to bit 0.
      pulse_bus = 32'h8000_0000;
      bus.enable_mask = 32'h8000_0001;
      bus.dwell = 16'd2;
      bus.loop = 1'b1;
      bus.start = 1'b1;
      push_ch(0, 2, 1'b0); push_ch(31, 2, 1'b0);
      push_ch(0, 2, 1'b1); push_ch(31, 2, 1'b0);
      push_ch(0, 1, 1'b1);
      drain(5, "loop_p1");
      chk("loop.hit_first_pass", bus.hit_mask, 32'h8000_0000);
      drain(4, "loop_p2");
      bus.abort = 1'b1;
      push(32'h0, 5'd0, 1'b0, 1'b0);
      drain(1, "loop_abort");
      bus.abort = 1'b0;
      chk("loop.hit_after_abort", bus.hit_mask, 32'h8000_0000);

      // Abort in the middle of the second channel's dwell.
      setup_basic();
      push_ch(1, 3, 1'b0); push_ch(2, 2, 1'b0);
      drain(5, "abort_run");
      bus.abort = 1'b1;
      for (int k = 0; k < 6; k++) push(32'h0, 5'd2, 1'b0, 1'b0);
      drain(1, "abort");
      bus.abort = 1'b0;
      drain(5, "abort_idle");
      chk("abort.hit_kept", bus.hit_mask, 32'h8000_0000);

      // Inputs changed during SCAN are ignored; then reset mid-scan.
      setup_basic();
      push_ch(1, 2, 1'b0);
      drain(2, "ignore");
      bus.enable_mask = 32'hFFFF_FFFF;
      bus.dwell = 16'd7;
      bus.loop = 1'b1;
      bus.start = 1'b1;
      push_ch(1, 1, 1'b0); push_ch(2, 3, 1'b0); push_ch(4, 1, 1'b0);
      drain(5, "ignore");
      rst = 1'b1;
      push(32'h0, 5'd0, 1'b0, 1'b0);
      drain(1, "rst_mid");
      chk("rst_mid.hit_mask", bus.hit_mask, 32'h0);
      rst = 1'b0;

      // Normal operation after reset.
      setup_basic();
      push_ch(1, 3, 1'b0); push_ch(2, 3, 1'b0); push_ch(4, 3, 1'b0);
      push(32'h0, 5'd4, 1'b0, 1'b1);
      drain(10, "after_rst");
      chk("after_rst.hit_mask", bus.hit_mask, 32'h0000_0002);
      chk("scoreboard.leftover", 32'(q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
